// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: round-robin arbiter handing out words from an external LFSR.
// Build option: define LFSR_ARBITER_WRAP_COUNT_EN to count i_LFSR_Done pulses.
module lfsr_arbiter #(
  parameter int NUM_BITS    = 4,
  parameter int STEP_CYCLES = 1
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [3:0]          i_Req,
  output logic [3:0]          o_Gnt,
  output logic [NUM_BITS-1:0] o_Rand_Data,
  output logic                o_Rand_DV,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  output logic                o_LFSR_Enable,
  output logic                o_LFSR_Seed_DV,
  output logic [NUM_BITS-1:0] o_LFSR_Seed_Data,
  input  logic [NUM_BITS-1:0] i_LFSR_Data,
  input  logic                i_LFSR_Done,
  output logic [15:0]         o_Wrap_Count
);

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    STEP,
    DELIVER
  } state_t;

  localparam logic [7:0] LAST_STEP = 8'(STEP_CYCLES - 1);

  state_t              state_q;
  state_t              state_d;
  logic [1:0]          ptr_q;
  logic [1:0]          win_q;
  logic [1:0]          win_idx;
  logic [1:0]          cand;
  logic                win_found;
  logic [7:0]          cnt_q;
  logic                seed_pend_q;
  logic [NUM_BITS-1:0] seed_q;
  logic [NUM_BITS-1:0] rand_q;
  logic                take_req;

  // IDLE accepts a request only when no seed is waiting
  assign take_req = (state_q == IDLE) && !seed_pend_q && (|i_Req);

  // Round-robin search starting at the pointer
  always_comb begin
    win_idx   = ptr_q;
    win_found = 1'b0;
    cand      = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && i_Req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and LFSR/grant output decode
  always_comb begin
    state_d          = state_q;
    o_Gnt            = 4'b0000;
    o_Rand_DV        = 1'b0;
    o_LFSR_Enable    = 1'b0;
    o_LFSR_Seed_DV   = 1'b0;
    o_LFSR_Seed_Data = '0;
    unique case (state_q)
      IDLE: begin
        if (seed_pend_q)
          state_d = SEED;
        else if (|i_Req)
          state_d = STEP;
      end
      SEED: begin
        o_LFSR_Enable    = 1'b1;
        o_LFSR_Seed_DV   = 1'b1;
        o_LFSR_Seed_Data = seed_q;
        state_d          = IDLE;
      end
      STEP: begin
        o_LFSR_Enable = 1'b1;
        if (cnt_q == LAST_STEP)
          state_d = DELIVER;
      end
      DELIVER: begin
        o_Rand_DV = 1'b1;
        unique case (win_q)
          2'd0: o_Gnt = 4'b0001;
          2'd1: o_Gnt = 4'b0010;
          2'd2: o_Gnt = 4'b0100;
          2'd3: o_Gnt = 4'b1000;
        endcase
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Delivered word is live in DELIVER and held afterwards
  assign o_Rand_Data = o_Rand_DV ? i_LFSR_Data : rand_q;

  // State, winner, step counter, pointer and held word
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      cnt_q   <= 8'd0;
      rand_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take_req) begin
        win_q <= win_idx;
        cnt_q <= 8'd0;
      end
      if (state_q == STEP)
        cnt_q <= cnt_q + 8'd1;
      if (state_q == DELIVER) begin
        ptr_q  <= win_q + 2'd1;
        rand_q <= i_LFSR_Data;
      end
    end
  end

  // Pending seed: a new pulse always wins over clearing in SEED
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      seed_pend_q <= 1'b0;
      seed_q      <= '0;
    end else if (i_Seed_DV) begin
      seed_pend_q <= 1'b1;
      seed_q      <= i_Seed_Data;
    end else if (state_q == SEED) begin
      seed_pend_q <= 1'b0;
    end
  end

`ifdef LFSR_ARBITER_WRAP_COUNT_EN
  logic [15:0] wrap_q;

  // Count LFSR wrap pulses seen while the LFSR is being clocked
  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      wrap_q <= 16'd0;
    else if (o_LFSR_Enable && i_LFSR_Done)
      wrap_q <= wrap_q + 16'd1;
  end

  assign o_Wrap_Count = wrap_q;
`else
  logic unused_done;

  assign unused_done  = i_LFSR_Done;
  assign o_Wrap_Count = 16'd0;
`endif

endmodule

// File: doc/lfsr_arbiter.md
LFSR_ARBITER -- requirements
Module: lfsr_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_BITS, 4, LFSR width (3..32); STEP_CYCLES, 1, LFSR enable cycles per delivered word (1..255).
REQ-002 Ports SHALL be: i_Clk  in  1  clock; i_Rst  in  1  reset, synchronous, active-high.
REQ-003 Port: i_Req  in  4  per-requester request, bit k = requester k.
REQ-004 Port: o_Gnt  out  4  one-hot grant, valid only with o_Rand_DV.
REQ-005 Port: o_Rand_Data  out  NUM_BITS  random word for the granted requester.
REQ-006 Port: o_Rand_DV  out  1  one-cycle strobe qualifying o_Gnt and o_Rand_Data.
REQ-007 Port: i_Seed_DV  in  1  seed-load request pulse; i_Seed_Data  in  NUM_BITS  seed value.
REQ-008 LFSR-side ports: o_LFSR_Enable  out  1; o_LFSR_Seed_DV  out  1; o_LFSR_Seed_Data  out  NUM_BITS; i_LFSR_Data  in  NUM_BITS; i_LFSR_Done  in  1.
REQ-009 Port: o_Wrap_Count  out  16  count of i_LFSR_Done pulses (see Configuration).

Function
REQ-010 FSM SHALL have states IDLE, SEED, STEP, DELIVER.
REQ-011 IDLE: seed pending -> SEED; otherwise any i_Req bit set -> STEP, latching the winner; otherwise stay IDLE.
REQ-012 Seed pending SHALL take priority over requests in IDLE.
REQ-013 Arbitration SHALL be round-robin: priority search starts at pointer P (reset 0); after a grant to k, P = (k+1) mod 4.
REQ-014 i_Req SHALL be sampled only in IDLE; deasserting a request after selection does not cancel the transaction.
REQ-015 SEED: one cycle with o_LFSR_Enable=1, o_LFSR_Seed_DV=1, o_LFSR_Seed_Data = pending seed; pending cleared; next state IDLE.
REQ-016 STEP: o_LFSR_Enable=1 for exactly STEP_CYCLES consecutive cycles, o_LFSR_Seed_DV=0; then DELIVER.
REQ-017 DELIVER: one cycle, o_Rand_DV=1, o_Gnt = one-hot of winner, o_Rand_Data = i_LFSR_Data; o_LFSR_Enable=0; next state IDLE.
REQ-018 Latency: request seen in IDLE at cycle N SHALL produce o_Rand_DV at cycle N+STEP_CYCLES+1.
REQ-019 Outside DELIVER, o_Gnt=0 and o_Rand_DV=0; o_Rand_Data holds its last delivered value.
REQ-020 i_Seed_DV in any state SHALL capture i_Seed_Data into a pending register; a second i_Seed_DV before application SHALL overwrite the value.
REQ-021 A seed arriving during STEP/DELIVER SHALL NOT abort the transaction; it is applied in the SEED visit following the return to IDLE.
REQ-022 i_Seed_DV coincident with the SEED cycle SHALL remain pending (new value) for the next IDLE.
REQ-023 o_LFSR_Enable SHALL be 0 in IDLE; the LFSR advances only under this block's control.

Reset
REQ-024 i_Rst SHALL synchronously force: state IDLE, P=0, seed-pending clear, o_Gnt=0, o_Rand_DV=0, o_Rand_Data=0, o_LFSR_Enable=0, o_LFSR_Seed_DV=0, o_LFSR_Seed_Data=0, o_Wrap_Count=0.
REQ-025 Reset asserted mid-transaction SHALL drop the in-flight grant with no o_Rand_DV pulse.

Configuration
REQ-026 Macro LFSR_ARBITER_WRAP_COUNT_EN defined: o_Wrap_Count increments by 1 on each cycle i_LFSR_Done=1 while o_LFSR_Enable=1, wrapping 16'hFFFF -> 0.
REQ-027 Macro LFSR_ARBITER_WRAP_COUNT_EN undefined: o_Wrap_Count SHALL be constant 0 and no counter logic is built.

Verification
REQ-028 NUM_BITS=4, STEP_CYCLES=1; i_Req=4'b0001 one cycle in IDLE -> o_LFSR_Enable high 1 cycle, then o_Rand_DV=1, o_Gnt=4'b0001, o_Rand_Data = i_LFSR_Data, 2 cycles after request.
REQ-029 i_Req=4'b1111 held -> grants 0001,0010,0100,1000,0001 in order, one every 3 cycles.
REQ-030 i_Seed_DV with seed 4'h9 during STEP -> current DELIVER completes, then SEED cycle drives o_LFSR_Seed_Data=4'h9, o_LFSR_Seed_DV=1.
REQ-031 Seed 4'h3 then 4'h5 before SEED, with i_Req=4'b0100 pending -> SEED applies 4'h5 first, grant 4'b0100 follows.
REQ-032 STEP_CYCLES=3, i_Rst pulsed during second STEP cycle -> no o_Rand_DV; all outputs 0 next cycle; next request granted to requester 0 first.
REQ-033 With LFSR_ARBITER_WRAP_COUNT_EN, NUM_BITS=4, continuous requests -> o_Wrap_Count increments once per 15 LFSR steps; undefined -> stays 0.
